// File: rtl/wb_pkg.sv
// Shared Wishbone constants plus the two-master arbiter state encoding.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  // Stalled-strobe counter width used by the timeout watchdog.
  localparam int TMO_CTR_W = 16;

  // Arbiter states; the owner states double as their one-hot grant value.
  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_OWN0 = 2'b01;
  localparam logic [1:0] ARB_OWN1 = 2'b10;

  // Map a state to the one-hot grant vector; any illegal code reads as idle.
  function automatic logic [1:0] grant_of(input logic [1:0] st);
    case (st)
      ARB_OWN0: grant_of = 2'b01;
      ARB_OWN1: grant_of = 2'b10;
      default:  grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Stalled-strobe watchdog: counts consecutive cycles with a strobe out and
// no slave response, and pulses expire on the last permitted cycle.
module wb_timeout_ctr
  import wb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 enable,   // strobe is out on the shared bus
  input  logic                 clear,    // slave responded this cycle
  input  logic [TMO_CTR_W-1:0] limit,
  output logic                 expire
);

  logic [TMO_CTR_W-1:0] count;

  // The count holds the number of earlier stalled cycles, so the limit-th
  // stalled cycle sees limit-1. A response arriving that same cycle is
  // ignored: the error wins and the count restarts.
  assign expire = enable && (count == (limit - TMO_CTR_W'(1)));

  // Count stalled cycles; restart on response, idle strobe or expiry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (expire || clear || !enable) begin
      count <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values, whatever the block evaluation order.
      count <= count + TMO_CTR_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter_rr2.sv
// Two-master Wishbone arbiter with round-robin tie-break, no preemption,
// one idle cycle between grants, and a stalled-strobe timeout.
module wb_arbiter_rr2
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,

  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [DATA_WIDTH/8-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,

  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [DATA_WIDTH/8-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,

  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [DATA_WIDTH/8-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,

  output logic [1:0]              o_grant,
  output logic                    o_timeout
);

  localparam logic [TMO_CTR_W-1:0] TMO_LIMIT = TMO_CTR_W'(TIMEOUT_CYCLES);

  logic [1:0] state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic       expire;
  logic       resp_ack, resp_err;

  // Arbitration: pick a new owner from idle, release when the owner's cyc drops.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed
    // branch would otherwise infer a latch.
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      ARB_IDLE: begin
        if (wbm0_cyc_i && wbm1_cyc_i) state_nxt = last_owner ? ARB_OWN0 : ARB_OWN1;
        else if (wbm0_cyc_i)          state_nxt = ARB_OWN0;
        else if (wbm1_cyc_i)          state_nxt = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!wbm0_cyc_i) begin
          state_nxt      = ARB_IDLE;
          last_owner_nxt = 1'b0;
        end
      end
      ARB_OWN1: begin
        if (!wbm1_cyc_i) begin
          state_nxt      = ARB_IDLE;
          last_owner_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Owner and round-robin history; reset favours master 0 on first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Shared-bus mux: the owner's signals pass straight through, idle drives zero.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    case (state)
      ARB_OWN0: begin
        wbs_adr_o = wbm0_adr_i;
        wbs_dat_o = wbm0_dat_i;
        wbs_we_o  = wbm0_we_i;
        wbs_sel_o = wbm0_sel_i;
        wbs_stb_o = wbm0_stb_i;
        wbs_cyc_o = wbm0_cyc_i;
      end
      ARB_OWN1: begin
        wbs_adr_o = wbm1_adr_i;
        wbs_dat_o = wbm1_dat_i;
        wbs_we_o  = wbm1_we_i;
        wbs_sel_o = wbm1_sel_i;
        wbs_stb_o = wbm1_stb_i;
        wbs_cyc_o = wbm1_cyc_i;
      end
      default: ;
    endcase
  end

  wb_timeout_ctr u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .enable  (wbs_stb_o),
    .clear   (wbs_ack_i || wbs_err_i),
    .limit   (TMO_LIMIT),
    .expire  (expire)
  );

  // Response shaping: error beats ack, timeout overrides the slave, and a
  // response seen while the owner has already dropped cyc is discarded.
  assign resp_err = (wbs_cyc_o && wbs_err_i) || expire;
  assign resp_ack = wbs_cyc_o && wbs_ack_i && !wbs_err_i && !expire;

  assign o_grant    = grant_of(state);
  assign o_timeout  = expire;
  assign wbm0_ack_o = o_grant[0] && resp_ack;
  assign wbm0_err_o = o_grant[0] && resp_err;
  assign wbm1_ack_o = o_grant[1] && resp_ack;
  assign wbm1_err_o = o_grant[1] && resp_err;
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// Self-checking bench for wb_arbiter_rr2: directed scenarios followed by a
// randomized run, all compared every cycle against a transaction-level model.
module tb_wb_arbiter_rr2;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Master-side stimulus, indexed by master number.
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic          m_we  [2];
  logic [SW-1:0] m_sel [2];
  logic          m_stb [2];
  logic          m_cyc [2];

  logic [DW-1:0] dat_o0, dat_o1;
  logic          ack0, ack1, err0, err1;
  logic [AW-1:0] wbs_adr;
  logic [DW-1:0] wbs_dat;
  logic          wbs_we, wbs_stb, wbs_cyc;
  logic [SW-1:0] wbs_sel;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err;
  logic [1:0]    grant;
  logic          timeout;

  wb_arbiter_rr2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]), .wbm0_dat_o(dat_o0),
    .wbm0_we_i(m_we[0]), .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]),
    .wbm0_cyc_i(m_cyc[0]), .wbm0_ack_o(ack0), .wbm0_err_o(err0),
    .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]), .wbm1_dat_o(dat_o1),
    .wbm1_we_i(m_we[1]), .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]),
    .wbm1_cyc_i(m_cyc[1]), .wbm1_ack_o(ack1), .wbm1_err_o(err1),
    .wbs_adr_o(wbs_adr), .wbs_dat_o(wbs_dat), .wbs_we_o(wbs_we),
    .wbs_sel_o(wbs_sel), .wbs_stb_o(wbs_stb), .wbs_cyc_o(wbs_cyc),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .o_grant(grant), .o_timeout(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 when nobody holds the bus, else master index.
  int owner;
  int last;
  int stalls;   // consecutive prior cycles with an unanswered strobe

  logic [1:0]    e_grant;
  logic          e_cyc, e_stb, e_we, e_tmo;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;
  logic [SW-1:0] e_sel;
  logic [1:0]    e_ack, e_err;

  task automatic model_reset();
    owner  = -1;
    last   = 1;
    stalls = 0;
  endtask

  task automatic ref_eval();
    e_grant = 2'b00; e_cyc = 0; e_stb = 0; e_we = 0; e_tmo = 0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_ack = 2'b00; e_err = 2'b00;
    if (owner >= 0) begin
      e_grant = (owner == 0) ? 2'b01 : 2'b10;
      e_cyc = m_cyc[owner]; e_stb = m_stb[owner]; e_we = m_we[owner];
      e_adr = m_adr[owner]; e_dat = m_dat[owner]; e_sel = m_sel[owner];
      e_tmo = e_stb && (stalls == TMO - 1);
      e_err[owner] = (e_cyc && s_err) || e_tmo;
      e_ack[owner] = e_cyc && s_ack && !s_err && !e_tmo;
    end
  endtask

  task automatic ref_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (e_stb && !s_ack && !s_err && !e_tmo) stalls++;
      else                                     stalls = 0;
      if (owner < 0) begin
        if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
        else if (m_cyc[0])        owner = 0;
        else if (m_cyc[1])        owner = 1;
      end else if (!m_cyc[owner]) begin
        last  = owner;
        owner = -1;
      end
    end
  endtask

  // ---------------- stimulus agents ----------------
  bit m_auto = 0, s_auto = 0, rand_start = 0, s_rand = 0;
  int act[2], beats[2], rounds[2];
  int s_cnt = 0, s_dly = 0, s_fix = 0;

  task automatic new_beat(input int m);
    m_adr[m] = $urandom;
    m_dat[m] = $urandom;
    m_we[m]  = 1'($urandom_range(0, 1));
    m_sel[m] = SW'($urandom_range(0, 15));
  endtask

  task automatic masters_drive();
    if (m_auto) for (int m = 0; m < 2; m++) begin
      m_cyc[m] = (act[m] != 0);
      m_stb[m] = (act[m] != 0);
    end
  endtask

  task automatic masters_update();
    if (m_auto) for (int m = 0; m < 2; m++) begin
      if (act[m] != 0 && (e_ack[m] || e_err[m])) begin
        beats[m]--;
        new_beat(m);
        if (beats[m] == 0) act[m] = 0;
      end else if (act[m] == 0) begin
        if (rounds[m] > 0) begin
          act[m] = 1; beats[m] = 3; rounds[m]--; new_beat(m);
        end else if (rand_start && $urandom_range(0, 3) == 0) begin
          act[m] = 1; beats[m] = $urandom_range(1, 4); new_beat(m);
        end
      end
    end
  endtask

  function automatic int pick_dly();
    int r;
    if (!s_rand) return s_fix;
    r = $urandom_range(0, 9);
    return (r < 7) ? (r % 4) : 20;
  endfunction

  task automatic slave_drive();
    int r;
    s_ack = 0; s_err = 0; s_dat = $urandom;
    if (e_stb && s_cnt >= s_dly) begin
      r = s_rand ? $urandom_range(0, 19) : 10;
      if (r == 0)     begin s_ack = 1; s_err = 1; end
      else if (r < 3) s_err = 1;
      else            s_ack = 1;
    end
  endtask

  task automatic slave_update();
    if (s_auto) begin
      if (e_stb && !(s_ack || s_err || e_tmo)) s_cnt++;
      else begin s_cnt = 0; s_dly = pick_dly(); end
    end
  endtask

  // ---------------- cycle helpers ----------------
  task automatic step_begin();
    if (!rst_n) model_reset();
    masters_drive();
    ref_eval();
    if (s_auto) begin slave_drive(); ref_eval(); end
    #4;
    check("grant",   64'(grant),   64'(e_grant));
    check("wbs_cyc", 64'(wbs_cyc), 64'(e_cyc));
    check("wbs_stb", 64'(wbs_stb), 64'(e_stb));
    check("wbs_we",  64'(wbs_we),  64'(e_we));
    check("wbs_adr", 64'(wbs_adr), 64'(e_adr));
    check("wbs_dat", 64'(wbs_dat), 64'(e_dat));
    check("wbs_sel", 64'(wbs_sel), 64'(e_sel));
    check("ack0",    64'(ack0),    64'(e_ack[0]));
    check("ack1",    64'(ack1),    64'(e_ack[1]));
    check("err0",    64'(err0),    64'(e_err[0]));
    check("err1",    64'(err1),    64'(e_err[1]));
    check("timeout", 64'(timeout), 64'(e_tmo));
    check("dat_o0",  64'(dat_o0),  64'(s_dat));
    check("dat_o1",  64'(dat_o1),  64'(s_dat));
  endtask

  task automatic step_end();
    @(posedge clk);
    ref_edge();
    masters_update();
    slave_update();
    #1;
  endtask

  task automatic step();
    step_begin();
    step_end();
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 0; m_stb[m] = 0; m_we[m] = 0;
      m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0;
      act[m] = 0; beats[m] = 0; rounds[m] = 0;
    end
    s_ack = 0; s_err = 0; s_dat = '0;
  endtask

  logic [1:0] exp_seq [4];
  int         segs[$];
  int         gaps[$];

  initial begin
    logic [1:0] prev;
    int zrun, fall_at, g1_at;

    idle_inputs();
    model_reset();
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    // Reset state, with a master already requesting.
    #1;
    m_cyc[0] = 1; m_stb[0] = 1;
    step_begin();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_cyc",   64'(wbs_cyc), 64'd0);
    step_end();
    step();
    m_cyc[0] = 0; m_stb[0] = 0;
    rst_n = 1;
    step();

    // Single read by m0, slave acks two cycles into the strobe.
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 0; m_adr[0] = 32'h0000_0004; m_sel[0] = 4'hF;
    step_begin(); check("r35_lat_idle", 64'(wbs_cyc), 64'd0); step_end();
    step_begin(); check("r35_lat_cyc",  64'(wbs_cyc), 64'd1); step_end();
    step();
    s_ack = 1; s_dat = 32'hA5A5_A5A5;
    step_begin();
    check("r35_ack0", 64'(ack0),   64'd1);
    check("r35_dat0", 64'(dat_o0), 64'hA5A5_A5A5);
    check("r35_ack1", 64'(ack1),   64'd0);
    step_end();
    s_ack = 0; m_cyc[0] = 0; m_stb[0] = 0;
    step(); step();

    // m1 strobes into a silent slave: error on every 8th stalled cycle.
    m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_adr[1] = 32'h100; m_dat[1] = 32'h1234_5678; m_sel[1] = 4'h3;
    for (int k = 0; k < 20; k++) begin
      step_begin();
      check("r37_tmo",  64'(timeout), 64'((k == 8) || (k == 16)));
      check("r37_err1", 64'(err1),    64'((k == 8) || (k == 16)));
      step_end();
    end
    m_cyc[1] = 0; m_stb[1] = 0;
    step(); step();

    // Both masters request together, three writes each, two rounds.
    m_auto = 1; s_auto = 1; s_rand = 0; s_fix = 0; s_cnt = 0; s_dly = 0;
    for (int m = 0; m < 2; m++) begin act[m] = 1; beats[m] = 3; rounds[m] = 1; new_beat(m); end
    prev = 2'b00; zrun = 0;
    for (int k = 0; k < 60; k++) begin
      step_begin();
      if (grant == 2'b00) zrun++;
      else begin
        if (prev == 2'b00) begin
          segs.push_back(int'(grant));
          if (segs.size() > 1) gaps.push_back(zrun);
        end
        zrun = 0;
      end
      prev = grant;
      step_end();
    end
    check("r36_nseg", 64'(segs.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("r36_seq", (i < segs.size()) ? 64'(segs[i]) : 64'd0, 64'(exp_seq[i]));
    foreach (gaps[i]) check("r36_gap", 64'(gaps[i]), 64'd1);

    // m0 holds cyc across a 4-beat burst while m1 waits.
    s_fix = 1; s_dly = 1;
    act[0] = 1; beats[0] = 4; new_beat(0);
    step();
    act[1] = 1; beats[1] = 1; new_beat(1);
    fall_at = -1; g1_at = -1;
    for (int k = 0; k < 40; k++) begin
      step_begin();
      if (fall_at < 0 && !m_cyc[0]) fall_at = k;
      if (g1_at < 0 && grant == 2'b10) g1_at = k;
      step_end();
    end
    check("r38_fall_seen", 64'(fall_at >= 0), 64'd1);
    check("r38_grant1_at", 64'(g1_at), 64'(fall_at + 2));
    m_auto = 0; s_auto = 0;
    idle_inputs();
    step();

    // Slave returns ack and err together to m0.
    m_cyc[0] = 1; m_stb[0] = 1; new_beat(0);
    step();
    s_ack = 1; s_err = 1;
    step_begin();
    check("r40_err0", 64'(err0), 64'd1);
    check("r40_ack0", 64'(ack0), 64'd0);
    step_end();
    s_ack = 0; s_err = 0; m_cyc[0] = 0; m_stb[0] = 0;
    step(); step();

    // Reset during a stalled m0 strobe; a late ack follows reset release.
    m_cyc[0] = 1; m_stb[0] = 1; new_beat(0);
    step(); step(); step();
    rst_n = 0; m_cyc[0] = 0; m_stb[0] = 0;
    step_begin();
    check("r39_rst_grant", 64'(grant), 64'd0);
    check("r39_rst_stb",   64'(wbs_stb), 64'd0);
    check("r39_rst_ack0",  64'(ack0), 64'd0);
    step_end();
    step();
    rst_n = 1; s_ack = 1;
    step_begin(); check("r39_late_ack0", 64'(ack0), 64'd0); step_end();
    s_ack = 0;
    m_cyc[0] = 1; m_stb[0] = 1; m_cyc[1] = 1; m_stb[1] = 1;
    step();
    step_begin(); check("r39_first_win", 64'(grant), 64'b01); step_end();
    m_cyc[0] = 0; m_stb[0] = 0; m_cyc[1] = 0; m_stb[1] = 0;
    step(); step();

    // Randomized traffic with random slave latency, errors and timeouts.
    idle_inputs();
    m_auto = 1; s_auto = 1; s_rand = 1; rand_start = 1; s_cnt = 0; s_dly = pick_dly();
    for (int k = 0; k < 1500; k++) step();
    rand_start = 0;
    for (int k = 0; k < 80; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr2.md
WB_ARBITER_RR2 -- requirements
Module: wb_arbiter_rr2

Interface
REQ-001 Parameter DATA_WIDTH, default 32, Wishbone data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, Wishbone address width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, stalled-strobe cycles before forced error; legal range 2..65535.
REQ-004 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 wbm{0,1}_adr_i  in  ADDR_WIDTH  master N address.
REQ-007 wbm{0,1}_dat_i  in  DATA_WIDTH  master N write data.
REQ-008 wbm{0,1}_dat_o  out  DATA_WIDTH  read data to master N.
REQ-009 wbm{0,1}_we_i  in  1  master N write enable.
REQ-010 wbm{0,1}_sel_i  in  DATA_WIDTH/8  master N byte select.
REQ-011 wbm{0,1}_stb_i  in  1  master N strobe.
REQ-012 wbm{0,1}_cyc_i  in  1  master N cycle/bus request.
REQ-013 wbm{0,1}_ack_o  out  1  acknowledge to master N.
REQ-014 wbm{0,1}_err_o  out  1  error to master N (slave error or timeout).
REQ-015 wbs_adr_o / wbs_dat_o / wbs_we_o / wbs_sel_o / wbs_stb_o / wbs_cyc_o  out  widths as master side  shared bus to downstream mux.
REQ-016 wbs_dat_i / wbs_ack_i / wbs_err_i  in  widths as master side  downstream response.
REQ-017 o_grant  out  2  one-hot current owner, 2'b00 when idle.
REQ-018 o_timeout  out  1  one-cycle pulse when a timeout error is issued.

Function
REQ-019 States IDLE, OWN0, OWN1, held in a registered FSM plus a registered last_owner bit.
REQ-020 IDLE: wbm0 cyc only -> OWN0; wbm1 cyc only -> OWN1; both -> master not equal to last_owner; none -> stay.
REQ-021 Grant latency: one cycle from cyc_i rise (in IDLE) to wbs_cyc_o high.
REQ-022 OWNn: wbs_* outputs combinationally equal master n signals; wbs_cyc_o = wbmn_cyc_i, wbs_stb_o = wbmn_stb_i; non-owner ack/err held 0.
REQ-023 IDLE: wbs_cyc_o, wbs_stb_o, wbs_we_o 0; adr/dat/sel 0; all ack/err 0.
REQ-024 wbm0_dat_o and wbm1_dat_o both = wbs_dat_i at all times.
REQ-025 OWNn exits to IDLE on the edge where wbmn_cyc_i is 0, setting last_owner = n; no preemption while cyc held, even mid-burst.
REQ-026 One IDLE cycle between consecutive grants; back-to-back requests from both masters alternate strictly.
REQ-027 Timeout counter (16 bits) increments each cycle with wbs_stb_o=1 and wbs_ack_i=0 and wbs_err_i=0; clears otherwise.
REQ-028 Counter reaching TIMEOUT_CYCLES-1: owner err_o=1 for that cycle, o_timeout=1, counter clears; wbs_ack_i ignored that cycle.
REQ-029 Slave ack and err both high same cycle: err forwarded, ack suppressed.
REQ-030 Owner dropping cyc with a pending unacknowledged strobe: release per REQ-025, counter clears, late slave ack discarded.

Reset
REQ-031 While i_rst_n=0: state IDLE, last_owner=1 (master 0 wins first contention), counter 0, o_grant 0, o_timeout 0, all wbs_* and ack/err outputs 0.
REQ-032 Reset assertion mid-transfer aborts immediately; no ack/err is issued for the aborted access after release.

Structure
REQ-033 State encoding and default widths live in shared package wb_pkg alongside existing Wishbone constants.
REQ-034 Timeout counter is a sub-module wb_timeout_ctr (enable, clear, limit, expire pulse); FSM and muxing stay in top.

Verification
REQ-035 m0 reads 0x00000004, slave acks after 2 cycles with 0xA5A5A5A5 -> wbs_cyc_o 1 cycle after request, m0 gets ack and data, m1 ack stays 0.
REQ-036 m0 and m1 raise cyc same cycle, each does 3 single writes and releases, repeated twice -> grants m0,m1,m0,m1 with one IDLE cycle between.
REQ-037 TIMEOUT_CYCLES=8, m1 strobes, slave never acks -> m1 err_o and o_timeout high exactly on 8th stalled cycle, counter restarts.
REQ-038 m0 holds cyc over 4-beat burst while m1 requests -> m1 not granted until cycle after m0 cyc falls.
REQ-039 i_rst_n pulled low during m0 stalled strobe, ack arrives after release -> all outputs 0 in reset, no ack to m0, next contention grants m0.
REQ-040 Slave returns ack and err together -> owner sees err_o=1, ack_o=0.
